// File: rtl/spi_sram_responder_if.sv
// spi_sram_responder_if
// ---------------------
// Groups the four-wire SPI bus (plus the responder's output enable) so the
// responder and whatever drives it can share one bundle.
//
// Signals:
//   SCK    - SPI clock from the master, idles low (mode 0)
//   CS_N   - chip select, active low
//   SI     - master-out / responder-in data
//   SO     - responder-out / master-in data
//   SO_OE  - high while the responder is actively driving SO
//
// Modports:
//   master - drives SCK/CS_N/SI, observes SO/SO_OE
//   slave  - observes SCK/CS_N/SI, drives SO/SO_OE
interface spi_sram_responder_if;
    logic SCK;
    logic CS_N;
    logic SI;
    logic SO;
    logic SO_OE;

    modport master (
        output SCK,
        output CS_N,
        output SI,
        input  SO,
        input  SO_OE
    );

    modport slave (
        input  SCK,
        input  CS_N,
        input  SI,
        output SO,
        output SO_OE
    );
endinterface

// File: rtl/spi_sram_responder.sv
// spi_sram_responder
// ------------------
// SPI mode-0 responder emulating a small serial SRAM with the 23LC512
// command set (READ 0x03, WRITE 0x02, RDSR 0x05, WRSR 0x01). The SPI pins are
// oversampled in the HCLK domain: each pin goes through a 2-flop synchronizer
// and a registered edge detector, so all logic runs on HCLK.
//
// Parameters:
//   ADDR_W   - implemented address bits (memory is 2^ADDR_W bytes; upper
//              bits of the 16-bit SPI address alias), must be > 5
//   SR_RESET - reset value of the mode/status register
//
// Ports:
//   HCLK     - system clock, at least 8x the SCK frequency
//   HRESETn  - asynchronous active-low reset (memory contents are kept)
//   HOLD_N   - optional hold input, present only with SPI_RESP_HOLD_EN
//   spi      - SPI bus (slave modport): SCK, CS_N, SI in; SO, SO_OE out
//
// Configuration macro:
//   SPI_RESP_HOLD_EN - when defined, adds HOLD_N. While synchronized HOLD_N
//                      is low and SCK is low, SCK edges are ignored, the FSM
//                      freezes and SO_OE is forced low.
module spi_sram_responder #(
    parameter int unsigned ADDR_W   = 10,
    parameter logic [7:0]  SR_RESET = 8'h40
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
`ifdef SPI_RESP_HOLD_EN
    input  logic                 HOLD_N,
`endif
    spi_sram_responder_if.slave  spi
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    localparam logic [7:0] OP_WRSR  = 8'h01;
    localparam logic [7:0] OP_WRITE = 8'h02;
    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_RDSR  = 8'h05;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR_H,
        ST_ADDR_L,
        ST_RDATA,
        ST_WDATA,
        ST_SR_R,
        ST_SR_W,
        ST_IGNORE
    } state_t;

    // Pin synchronizers and edge-detect delay stages
    logic sck_meta_q, sck_sync_q, sck_dly_q;
    logic cs_meta_q,  cs_sync_q,  cs_dly_q;
    logic si_meta_q,  si_sync_q;
    logic hold_active;

    // Protocol state
    state_t             state_q, state_d;
    logic [2:0]         bit_cnt_q, bit_cnt_d;
    logic [6:0]         rx_q, rx_d;
    logic [7:0]         tx_q, tx_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [7:0]         sr_q, sr_d;
    logic               is_read_q, is_read_d;
    logic               so_q, so_d;
    logic               so_oe_q, so_oe_d;
    logic               mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]  mem_waddr_q, mem_waddr_d;
    logic [7:0]         mem_wdata_q, mem_wdata_d;

    logic [7:0]         mem [DEPTH];
    logic [ADDR_W-1:0]  rd_addr;
    logic [7:0]         rd_data;

    logic               sck_rise, sck_fall, cs_fall, byte_done, byte_mode;
    logic [7:0]         rx_byte;
    logic [ADDR_W-1:0]  addr_shift, addr_inc;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            sck_meta_q <= 1'b0;
            sck_sync_q <= 1'b0;
            sck_dly_q  <= 1'b0;
            cs_meta_q  <= 1'b1;
            cs_sync_q  <= 1'b1;
            cs_dly_q   <= 1'b1;
            si_meta_q  <= 1'b0;
            si_sync_q  <= 1'b0;
        end else begin
            sck_meta_q <= spi.SCK;
            sck_sync_q <= sck_meta_q;
            sck_dly_q  <= sck_sync_q;
            cs_meta_q  <= spi.CS_N;
            cs_sync_q  <= cs_meta_q;
            cs_dly_q   <= cs_sync_q;
            si_meta_q  <= spi.SI;
            si_sync_q  <= si_meta_q;
        end
    end

`ifdef SPI_RESP_HOLD_EN
    logic hold_meta_q, hold_sync_q;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            hold_meta_q <= 1'b1;
            hold_sync_q <= 1'b1;
        end else begin
            hold_meta_q <= HOLD_N;
            hold_sync_q <= hold_meta_q;
        end
    end

    // Hold only takes effect once SCK is low, so a byte is never paused mid-pulse
    assign hold_active = ~hold_sync_q & ~sck_sync_q;
`else
    assign hold_active = 1'b0;
`endif

    // SCK edges count only while selected and not held; SI is aligned with
    // the SCK sync stage so it is captured on the cycle the rise is seen.
    assign cs_fall    = ~cs_sync_q & cs_dly_q;
    assign sck_rise   = ~cs_sync_q & ~hold_active & sck_sync_q & ~sck_dly_q;
    assign sck_fall   = ~cs_sync_q & ~hold_active & ~sck_sync_q & sck_dly_q;
    assign rx_byte    = {rx_q, si_sync_q};
    assign byte_done  = sck_rise & (bit_cnt_q == 3'd7);
    // Shifting the address MSB-first drops the unimplemented upper bits
    assign addr_shift = {addr_q[ADDR_W-2:0], si_sync_q};
    // Modes 00 and 11 both mean single-byte access
    assign byte_mode  = (sr_q[7] == sr_q[6]);
    assign rd_data    = mem[rd_addr];

    always_comb begin
        addr_inc = addr_q;
        case (sr_q[7:6])
            2'b01:   addr_inc = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
            2'b10:   addr_inc = {addr_q[ADDR_W-1:5], addr_q[4:0] + 5'd1};
            default: addr_inc = addr_q;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        rx_d        = rx_q;
        tx_d        = tx_q;
        addr_d      = addr_q;
        sr_d        = sr_q;
        is_read_d   = is_read_q;
        so_d        = so_q;
        so_oe_d     = so_oe_q;
        mem_we_d    = 1'b0;
        mem_waddr_d = mem_waddr_q;
        mem_wdata_d = mem_wdata_q;
        rd_addr     = addr_q;

        if (cs_sync_q) begin
            // Deselect aborts everything; partial bytes are simply dropped
            state_d   = ST_IDLE;
            bit_cnt_d = 3'd0;
            so_d      = 1'b0;
            so_oe_d   = 1'b0;
        end else if (state_q == ST_IDLE) begin
            if (cs_fall) begin
                state_d   = ST_CMD;
                bit_cnt_d = 3'd0;
            end
        end else begin
            if (sck_rise) begin
                bit_cnt_d = bit_cnt_q + 3'd1;
                rx_d      = rx_byte[6:0];
            end

            case (state_q)
                ST_CMD: begin
                    if (byte_done) begin
                        case (rx_byte)
                            OP_READ: begin
                                state_d   = ST_ADDR_H;
                                is_read_d = 1'b1;
                            end
                            OP_WRITE: begin
                                state_d   = ST_ADDR_H;
                                is_read_d = 1'b0;
                            end
                            OP_RDSR: begin
                                state_d = ST_SR_R;
                                tx_d    = sr_q;
                            end
                            OP_WRSR: state_d = ST_SR_W;
                            default: state_d = ST_IGNORE;
                        endcase
                    end
                end

                ST_ADDR_H: begin
                    if (sck_rise) addr_d = addr_shift;
                    if (byte_done) state_d = ST_ADDR_L;
                end

                ST_ADDR_L: begin
                    if (sck_rise) addr_d = addr_shift;
                    if (byte_done) begin
                        if (is_read_q) begin
                            state_d = ST_RDATA;
                            rd_addr = addr_shift;
                            tx_d    = rd_data;
                        end else begin
                            state_d = ST_WDATA;
                        end
                    end
                end

                // SO is driven from a register updated on each SCK fall; the
                // fall right after a load presents bit 7.
                ST_RDATA: begin
                    if (sck_fall) begin
                        so_d    = tx_q[7];
                        tx_d    = {tx_q[6:0], 1'b0};
                        so_oe_d = 1'b1;
                    end
                    if (byte_done) begin
                        if (byte_mode) begin
                            state_d = ST_IGNORE;
                            so_d    = 1'b0;
                            so_oe_d = 1'b0;
                        end else begin
                            addr_d  = addr_inc;
                            rd_addr = addr_inc;
                            tx_d    = rd_data;
                        end
                    end
                end

                ST_WDATA: begin
                    if (byte_done) begin
                        mem_we_d    = 1'b1;
                        mem_waddr_d = addr_q;
                        mem_wdata_d = rx_byte;
                        if (byte_mode) state_d = ST_IGNORE;
                        else           addr_d  = addr_inc;
                    end
                end

                ST_SR_R: begin
                    if (sck_fall) begin
                        so_d    = tx_q[7];
                        tx_d    = {tx_q[6:0], 1'b0};
                        so_oe_d = 1'b1;
                    end
                    if (byte_done) tx_d = sr_q;
                end

                ST_SR_W: begin
                    if (byte_done) begin
                        sr_d    = rx_byte;
                        state_d = ST_IGNORE;
                    end
                end

                default: ;
            endcase
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 3'd0;
            rx_q        <= 7'd0;
            tx_q        <= 8'd0;
            addr_q      <= '0;
            sr_q        <= SR_RESET;
            is_read_q   <= 1'b0;
            so_q        <= 1'b0;
            so_oe_q     <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_waddr_q <= '0;
            mem_wdata_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            addr_q      <= addr_d;
            sr_q        <= sr_d;
            is_read_q   <= is_read_d;
            so_q        <= so_d;
            so_oe_q     <= so_oe_d;
            mem_we_q    <= mem_we_d;
            mem_waddr_q <= mem_waddr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Storage array has no reset so contents survive HRESETn
    always_ff @(posedge HCLK) begin
        if (mem_we_q) mem[mem_waddr_q] <= mem_wdata_q;
    end

    assign spi.SO    = so_q;
    assign spi.SO_OE = so_oe_q & ~hold_active;

endmodule

// File: tb/tb_spi_sram_responder.sv
// tb_spi_sram_responder
// ---------------------
// Self-checking bench for spi_sram_responder. Acts as a mode-0 SPI master
// (SCK period 16 HCLK) and compares read data and SO_OE against a reference
// model of the SRAM: a byte array plus the status register, with address
// sequencing computed arithmetically from the mode bits.
module tb_spi_sram_responder;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int HALF   = 8;

    logic hclk = 1'b0;
    logic hresetn;
`ifdef SPI_RESP_HOLD_EN
    logic hold_n = 1'b1;
`endif

    always #5 hclk = ~hclk;

    spi_sram_responder_if spi_bus();

    spi_sram_responder #(
        .ADDR_W   (ADDR_W),
        .SR_RESET (8'h40)
    ) dut (
        .HCLK    (hclk),
        .HRESETn (hresetn),
`ifdef SPI_RESP_HOLD_EN
        .HOLD_N  (hold_n),
`endif
        .spi     (spi_bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [7:0] ref_mem   [DEPTH];
    bit         ref_known [DEPTH];
    logic [7:0] ref_sr;

    logic [7:0] tx_buf     [32];
    logic [7:0] rx_buf     [32];
    logic       oe_buf     [32];
    logic       oe_any_buf [32];
    logic [7:0] wr_data    [16];

    task automatic wait_clk(input int n);
        repeat (n) @(negedge hclk);
    endtask

    // Shift nbits of tx MSB-first; SO/SO_OE sampled just before each rise
    task automatic spi_bits(input logic [7:0] tx, input int nbits,
                            output logic [7:0] rx, output logic oe_all,
                            output logic oe_any);
        rx     = 8'd0;
        oe_all = 1'b1;
        oe_any = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            spi_bus.SI = tx[7-i];
            wait_clk(HALF);
            rx     = {rx[6:0], spi_bus.SO};
            oe_all = oe_all & spi_bus.SO_OE;
            oe_any = oe_any | spi_bus.SO_OE;
            spi_bus.SCK = 1'b1;
            wait_clk(HALF);
            spi_bus.SCK = 1'b0;
        end
    endtask

    task automatic run_txn(input int n);
        logic [7:0] r;
        logic oa, on;
        spi_bus.CS_N = 1'b0;
        wait_clk(HALF);
        for (int k = 0; k < n; k++) begin
            spi_bits(tx_buf[k], 8, r, oa, on);
            rx_buf[k]     = r;
            oe_buf[k]     = oa;
            oe_any_buf[k] = on;
        end
        wait_clk(HALF);
        spi_bus.CS_N = 1'b1;
        wait_clk(8);
    endtask

    // Next address after a data byte, or -1 when the mode allows only one
    function automatic int model_next(input int a);
        case (ref_sr[7:6])
            2'b01:   return (a + 1) % DEPTH;
            2'b10:   return (a & ~31) | ((a + 1) & 31);
            default: return -1;
        endcase
    endfunction

    task automatic do_write(input int addr, input int n);
        int a;
        tx_buf[0] = 8'h02;
        tx_buf[1] = 8'((addr >> 8) & 8'hFF);
        tx_buf[2] = 8'(addr & 8'hFF);
        for (int k = 0; k < n; k++) tx_buf[3+k] = wr_data[k];
        run_txn(3 + n);
        a = addr % DEPTH;
        for (int k = 0; k < n; k++) begin
            if (a < 0) break;
            ref_mem[a]   = wr_data[k];
            ref_known[a] = 1'b1;
            a = model_next(a);
        end
    endtask

    task automatic do_read_check(input int addr, input int n, input string tag);
        int a;
        tx_buf[0] = 8'h03;
        tx_buf[1] = 8'((addr >> 8) & 8'hFF);
        tx_buf[2] = 8'(addr & 8'hFF);
        for (int k = 0; k < n; k++) tx_buf[3+k] = 8'h00;
        run_txn(3 + n);
        checks++;
        if ((oe_any_buf[0] | oe_any_buf[1] | oe_any_buf[2]) !== 1'b0) begin
            failures++;
            $display("[TB] FAIL %s_oe_hdr: SO_OE got 1 during cmd/addr, expected 0", tag);
        end
        a = addr % DEPTH;
        for (int k = 0; k < n; k++) begin
            if (a < 0) break;
            if (ref_known[a]) begin
                checks++;
                if (rx_buf[3+k] !== ref_mem[a]) begin
                    failures++;
                    $display("[TB] FAIL %s_data%0d: mem[%h] got %h expected %h",
                             tag, k, a, rx_buf[3+k], ref_mem[a]);
                end
            end
            checks++;
            if (oe_buf[3+k] !== 1'b1) begin
                failures++;
                $display("[TB] FAIL %s_oe%0d: SO_OE got %b expected 1", tag, k, oe_buf[3+k]);
            end
            a = model_next(a);
        end
    endtask

    task automatic do_wrsr(input logic [7:0] v);
        tx_buf[0] = 8'h01;
        tx_buf[1] = v;
        tx_buf[2] = 8'h5A;
        run_txn(3);
        ref_sr = v;
    endtask

    task automatic do_rdsr_check(input int n, input string tag);
        tx_buf[0] = 8'h05;
        for (int k = 0; k < n; k++) tx_buf[1+k] = 8'h00;
        run_txn(1 + n);
        checks++;
        if (oe_any_buf[0] !== 1'b0) begin
            failures++;
            $display("[TB] FAIL %s_oe_cmd: SO_OE got 1 during command, expected 0", tag);
        end
        for (int k = 0; k < n; k++) begin
            checks++;
            if (rx_buf[1+k] !== ref_sr || oe_buf[1+k] !== 1'b1) begin
                failures++;
                $display("[TB] FAIL %s_sr%0d: got %h oe=%b expected %h oe=1",
                         tag, k, rx_buf[1+k], oe_buf[1+k], ref_sr);
            end
        end
        checks++;
        if (spi_bus.SO_OE !== 1'b0) begin
            failures++;
            $display("[TB] FAIL %s_oe_idle: SO_OE got %b expected 0", tag, spi_bus.SO_OE);
        end
    endtask

    task automatic test_reset();
        hresetn      = 1'b0;
        spi_bus.CS_N = 1'b1;
        spi_bus.SCK  = 1'b0;
        spi_bus.SI   = 1'b0;
        ref_sr       = 8'h40;
        wait_clk(3);
        checks++;
        if (spi_bus.SO_OE !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_so_oe: got %b expected 0", spi_bus.SO_OE);
        end
        checks++;
        if (spi_bus.SO !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_so: got %b expected 0", spi_bus.SO);
        end
        hresetn = 1'b1;
        wait_clk(5);
    endtask

    task automatic test_rdsr();
        do_rdsr_check(3, "rdsr");
    endtask

    task automatic test_seq_write_read();
        wr_data[0] = 8'hA5;
        wr_data[1] = 8'h5A;
        wr_data[2] = 8'hC3;
        do_write(16'h0010, 3);
        do_read_check(16'h0010, 3, "seq");
    endtask

    task automatic test_page_mode();
        do_wrsr(8'h80);
        wr_data[0] = 8'h11;
        wr_data[1] = 8'h22;
        wr_data[2] = 8'h33;
        wr_data[3] = 8'h44;
        do_write(16'h001E, 4);
        do_wrsr(8'h40);
        do_read_check(16'h0000, 2, "page_lo");
        do_read_check(16'h001E, 2, "page_hi");
    endtask

    task automatic test_byte_mode();
        wr_data[0] = 8'($urandom_range(0, 255));
        wr_data[1] = 8'($urandom_range(0, 255));
        do_write(16'h0005, 2);
        do_wrsr(8'h00);
        do_rdsr_check(2, "rdsr_byte");
        wr_data[0] = 8'hAA;
        wr_data[1] = 8'hBB;
        do_write(16'h0005, 2);
        do_wrsr(8'h40);
        do_read_check(16'h0005, 2, "byte");
    endtask

    task automatic test_sr_bits();
        do_wrsr({2'b01, 6'($urandom_range(0, 63))});
        do_rdsr_check(2, "sr_bits");
        do_wrsr(8'h40);
    endtask

    task automatic test_interrupted();
        logic [7:0] r;
        logic oa, on;
        wr_data[0] = 8'($urandom_range(0, 255));
        do_write(16'h0020, 1);
        spi_bus.CS_N = 1'b0;
        wait_clk(HALF);
        spi_bits(8'h02, 8, r, oa, on);
        spi_bits(8'h00, 8, r, oa, on);
        spi_bits(8'h20, 8, r, oa, on);
        spi_bits(~ref_mem[16'h20], 5, r, oa, on);
        wait_clk(HALF);
        spi_bus.CS_N = 1'b1;
        wait_clk(8);
        do_read_check(16'h0020, 1, "partial_wr");
    endtask

    task automatic test_illegal_opcode();
        logic any;
        tx_buf[0] = 8'hFF;
        tx_buf[1] = 8'h03;
        tx_buf[2] = 8'h00;
        tx_buf[3] = 8'h10;
        tx_buf[4] = 8'h00;
        run_txn(5);
        any = 1'b0;
        for (int k = 0; k < 5; k++) any = any | oe_any_buf[k];
        checks++;
        if (any !== 1'b0) begin
            failures++;
            $display("[TB] FAIL illegal_oe: SO_OE got 1 during 0xFF transaction, expected 0");
        end
    endtask

    task automatic test_reset_mid_read();
        logic [7:0] r;
        logic oa, on;
        do_wrsr(8'h80);
        spi_bus.CS_N = 1'b0;
        wait_clk(HALF);
        spi_bits(8'h03, 8, r, oa, on);
        spi_bits(8'h00, 8, r, oa, on);
        spi_bits(8'h10, 8, r, oa, on);
        spi_bits(8'h00, 4, r, oa, on);
        wait_clk(2);
        hresetn = 1'b0;
        #1;
        checks++;
        if (spi_bus.SO_OE !== 1'b0 || spi_bus.SO !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_mid: SO_OE=%b SO=%b expected 0 0",
                     spi_bus.SO_OE, spi_bus.SO);
        end
        wait_clk(3);
        spi_bus.CS_N = 1'b1;
        wait_clk(2);
        hresetn = 1'b1;
        ref_sr  = 8'h40;
        wait_clk(8);
        do_rdsr_check(1, "rdsr_after_rst");
        do_read_check(16'h0010, 3, "mem_kept");
    endtask

    task automatic test_wrap_alias();
        wr_data[0] = 8'($urandom_range(0, 255));
        wr_data[1] = 8'($urandom_range(0, 255));
        do_write(16'h03FF, 2);
        do_read_check(16'h03FF, 2, "wrap");
        do_read_check(16'h0410, 1, "alias");
    endtask

    task automatic test_random();
        for (int t = 0; t < 6; t++) begin
            logic [1:0] mode;
            int addr, n;
            mode = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
            do_wrsr({mode, 6'($urandom_range(0, 63))});
            addr = int'($urandom_range(0, 16'hFFFF));
            n    = int'($urandom_range(1, 4));
            for (int k = 0; k < n; k++) wr_data[k] = 8'($urandom_range(0, 255));
            do_write(addr, n);
            do_read_check(addr, n, $sformatf("rand%0d", t));
        end
        do_wrsr(8'h40);
    endtask

    initial begin
        test_reset();
        test_rdsr();
        test_seq_write_read();
        test_page_mode();
        test_byte_mode();
        test_sr_bits();
        test_interrupted();
        test_illegal_opcode();
        test_reset_mid_read();
        test_wrap_alias();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
